// File: rtl/result_bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD result converter: default geometry,
// FSM state encoding and the double-dabble correction constants.
package result_bcd_converter_pkg;

  localparam int DATA_W = 16;
  localparam int DIGITS = 5;
  localparam int CNT_W  = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // A digit at or above this threshold would overflow past 9 when doubled
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/result_bcd_converter_adjust.sv
// Combinational add-3 correction for a single BCD digit, applied before
// each double-dabble shift.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  import result_bcd_converter_pkg::*;

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADJ_THRESH) begin
      digit_o = digit_i + ADJ_ADD;
    end
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: turns a signed or unsigned binary
// result into packed BCD digits plus a separate sign flag.
module result_bcd_converter #(
  parameter int DATA_W = result_bcd_converter_pkg::DATA_W,
  parameter int DIGITS = result_bcd_converter_pkg::DIGITS
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative
);
  import result_bcd_converter_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] mag_q,   mag_d;
  logic [BCD_W-1:0]  acc_q,   acc_d;
  logic              sign_q,  sign_d;
  logic [BCD_W-1:0]  bcd_q,   bcd_d;
  logic              neg_q,   neg_d;
  logic              done_q,  done_d;

  logic [BCD_W-1:0]  acc_adj;
  logic              value_neg;
  logic [DATA_W-1:0] value_mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // Negating the most negative value wraps to itself, which is the correct
  // unsigned magnitude, so no extra width is needed.
  assign value_neg = is_signed & value[DATA_W-1];
  assign value_mag = value_neg ? -value : value;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d   = value_mag;
          acc_d   = '0;
          cnt_d   = '0;
          sign_d  = value_neg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = acc_q;
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign negative = neg_q;

endmodule
